// File: rtl/tlb_refill_walker.sv
// Single-level page-table walker: turns a User-mode TLB miss into one PTE read,
// then either fills the TLB or reports a walk fault (invalid PTE or timeout).

`ifndef THR_PER_CORE_WIDTH
`define THR_PER_CORE_WIDTH 2
`endif

package tlb_refill_walker_pkg;
    localparam int VIRT_ADDR_W = 32;
    localparam int PHY_ADDR_W  = 20;

    typedef struct packed {
        logic [VIRT_ADDR_W-1:0] virt_addr;
        logic [PHY_ADDR_W-1:0]  phy_addr;
    } tlb_req_info_t;
endpackage

// state    | meaning
// IDLE     | miss_ready=1, waiting for a TLB miss
// REQ      | PTE read request held until the arbiter accepts it
// WAIT_RSP | waiting for PTE data, timeout counter running
// FILL     | one-cycle new_tlb_entry pulse
// FAULT    | one-cycle walk_fault pulse
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int VA_WIDTH         = VIRT_ADDR_W,
    parameter int PA_WIDTH         = PHY_ADDR_W,
    parameter int PAGE_OFFSET_BITS = 12,
    parameter int PTE_BYTES        = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           miss_valid,
    output logic                           miss_ready,
    input  logic [`THR_PER_CORE_WIDTH-1:0] miss_thread_id,
    input  logic [VA_WIDTH-1:0]            miss_virt_addr,
    input  logic [PA_WIDTH-1:0]            pt_base,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [PA_WIDTH-1:0]            mem_req_addr,
    input  logic                           mem_rsp_valid,
    input  logic [31:0]                    mem_rsp_data,
    output logic                           new_tlb_entry,
    output logic [`THR_PER_CORE_WIDTH-1:0] new_tlb_thread_id,
    output tlb_req_info_t                  new_tlb_info,
    output logic                           walk_fault,
    output logic [`THR_PER_CORE_WIDTH-1:0] fault_thread_id
);

    localparam int PTE_SHIFT   = $clog2(PTE_BYTES);
    localparam int CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PPN_W       = PA_WIDTH - PAGE_OFFSET_BITS;
    localparam int PTE_PPN_LSB = 12;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, FILL, FAULT} state_t;

    state_t                           state_q;
    logic                             miss_ready_q;
    logic                             req_valid_q;
    logic [PA_WIDTH-1:0]              req_addr_q;
    logic [VA_WIDTH-1:0]              va_q;
    logic [`THR_PER_CORE_WIDTH-1:0]   thr_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             pte_write_q;
    logic                             new_entry_q;
    logic [`THR_PER_CORE_WIDTH-1:0]   new_thr_q;
    tlb_req_info_t                    new_info_q;
    logic                             fault_q;
    logic [`THR_PER_CORE_WIDTH-1:0]   fault_thr_q;

    logic [VA_WIDTH-1:0]              vpn_scaled;
    logic [PA_WIDTH-1:0]              pte_addr_d;

    // VPN*PTE_BYTES as a shift; the add wraps silently at PA_WIDTH.
    assign vpn_scaled = (miss_virt_addr >> PAGE_OFFSET_BITS) << PTE_SHIFT;
    assign pte_addr_d = pt_base + vpn_scaled[PA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            va_q         <= '0;
            thr_q        <= '0;
            cnt_q        <= '0;
            pte_write_q  <= 1'b0;
            new_entry_q  <= 1'b0;
            new_thr_q    <= '0;
            new_info_q   <= '0;
            fault_q      <= 1'b0;
            fault_thr_q  <= '0;
        end else begin
            new_entry_q <= 1'b0;
            fault_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid) begin
                        va_q         <= miss_virt_addr;
                        thr_q        <= miss_thread_id;
                        req_addr_q   <= pte_addr_d;
                        req_valid_q  <= 1'b1;
                        miss_ready_q <= 1'b0;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response on the limit cycle takes priority over the timeout.
                    if (mem_rsp_valid) begin
                        pte_write_q <= mem_rsp_data[1];
                        if (mem_rsp_data[0]) begin
                            new_info_q.virt_addr <= va_q;
                            new_info_q.phy_addr  <= {mem_rsp_data[PTE_PPN_LSB +: PPN_W],
                                                     va_q[PAGE_OFFSET_BITS-1:0]};
                            new_thr_q            <= thr_q;
                            new_entry_q          <= 1'b1;
                            state_q              <= FILL;
                        end else begin
                            fault_thr_q <= thr_q;
                            fault_q     <= 1'b1;
                            state_q     <= FAULT;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        fault_thr_q <= thr_q;
                        fault_q     <= 1'b1;
                        state_q     <= FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FILL, FAULT: begin
                    miss_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miss_ready        = miss_ready_q;
    assign mem_req_valid     = req_valid_q;
    assign mem_req_addr      = req_addr_q;
    assign new_tlb_entry     = new_entry_q;
    assign new_tlb_thread_id = new_thr_q;
    assign new_tlb_info      = new_info_q;
    assign walk_fault        = fault_q;
    assign fault_thread_id   = fault_thr_q;

    // PTE write bit is kept only as a debug probe; the TLB forces writePriv.
    logic unused_ok;
    assign unused_ok = ^{mem_rsp_data[31:PTE_PPN_LSB+PPN_W], mem_rsp_data[PTE_PPN_LSB-1:2],
                         vpn_scaled[VA_WIDTH-1:PA_WIDTH], pte_write_q};

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed plus randomized bench for tlb_refill_walker, checked against an
// arithmetic model of the PTE address, translation and walk timing.

`ifndef THR_PER_CORE_WIDTH
`define THR_PER_CORE_WIDTH 2
`endif

module tb_tlb_refill_walker;
    import tlb_refill_walker_pkg::*;

    localparam int THR_W   = `THR_PER_CORE_WIDTH;
    localparam int TIMEOUT = 255;

    logic             clock = 1'b0;
    logic             reset;
    logic             miss_valid;
    logic             miss_ready;
    logic [THR_W-1:0] miss_thread_id;
    logic [31:0]      miss_virt_addr;
    logic [19:0]      pt_base;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [19:0]      mem_req_addr;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rsp_data;
    logic             new_tlb_entry;
    logic [THR_W-1:0] new_tlb_thread_id;
    tlb_req_info_t    new_tlb_info;
    logic             walk_fault;
    logic [THR_W-1:0] fault_thread_id;

    int vectors     = 0;
    int miscompares = 0;

    tlb_refill_walker dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_thread_id(miss_thread_id), .miss_virt_addr(miss_virt_addr), .pt_base(pt_base),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .new_tlb_entry(new_tlb_entry), .new_tlb_thread_id(new_tlb_thread_id),
        .new_tlb_info(new_tlb_info),
        .walk_fault(walk_fault), .fault_thread_id(fault_thread_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on page numbers.
    function automatic logic [19:0] model_pte_addr(input logic [19:0] base, input logic [31:0] va);
        longint unsigned a;
        a = (longint'(base) + longint'(va / 4096) * 4) % 64'h100000;
        return a[19:0];
    endfunction

    function automatic logic [19:0] model_phy(input logic [31:0] pte, input logic [31:0] va);
        longint unsigned p;
        p = ((longint'(pte) / 4096) % 256) * 4096 + (longint'(va) % 4096);
        return p[19:0];
    endfunction

    // Called at an IDLE negedge; returns at the negedge of the REQ cycle.
    task automatic issue(input logic [THR_W-1:0] thr, input logic [31:0] va, input logic [19:0] base);
        check("idle_miss_ready", miss_ready, 1);
        miss_valid     = 1'b1;
        miss_thread_id = thr;
        miss_virt_addr = va;
        pt_base        = base;
        @(negedge clock);
        miss_valid     = 1'b0;
        pt_base        = 20'($urandom);
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_addr, model_pte_addr(base, va));
        check("busy_miss_ready", miss_ready, 0);
    endtask

    // Runs the rest of a walk from the REQ negedge; returns at the following IDLE negedge.
    task automatic finish(input int stall, input int rsp_delay, input logic [31:0] pte, input bit no_rsp,
                          input logic [THR_W-1:0] thr, input logic [31:0] va, input logic [19:0] base);
        int n;
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clock);
            check("stall_valid", mem_req_valid, 1);
            check("stall_addr", mem_req_addr, model_pte_addr(base, va));
            check("stall_miss_ready", miss_ready, 0);
        end
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        check("req_drop", mem_req_valid, 0);
        if (no_rsp) begin
            n = 0;
            while (walk_fault !== 1'b1 && n < 400) begin
                @(negedge clock);
                n++;
            end
            check("timeout_cycles", n, TIMEOUT + 1);
            check("timeout_thr", fault_thread_id, thr);
            check("timeout_no_fill", new_tlb_entry, 0);
        end else begin
            for (int i = 0; i < rsp_delay; i++) begin
                @(negedge clock);
                if (new_tlb_entry !== 1'b0 || walk_fault !== 1'b0)
                    check("early_pulse", {new_tlb_entry, walk_fault}, 0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pte;
            @(negedge clock);
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
            if (pte[0]) begin
                check("fill_pulse", new_tlb_entry, 1);
                check("fill_no_fault", walk_fault, 0);
                check("fill_thr", new_tlb_thread_id, thr);
                check("fill_va", new_tlb_info.virt_addr, va);
                check("fill_pa", new_tlb_info.phy_addr, model_phy(pte, va));
            end else begin
                check("fault_pulse", walk_fault, 1);
                check("fault_no_fill", new_tlb_entry, 0);
                check("fault_thr", fault_thread_id, thr);
            end
            check("pulse_miss_ready", miss_ready, 0);
        end
        @(negedge clock);
        check("pulse_one_cycle", {new_tlb_entry, walk_fault}, 0);
        check("back_miss_ready", miss_ready, 1);
    endtask

    initial begin
        logic [THR_W-1:0] thr;
        logic [31:0]      va;
        logic [19:0]      base;
        logic [31:0]      pte;

        reset = 1'b1; miss_valid = 1'b0; miss_thread_id = '0; miss_virt_addr = '0; pt_base = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_miss_ready", miss_ready, 1);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_pulses", {new_tlb_entry, walk_fault}, 0);
        check("rst_info", new_tlb_info, 0);
        check("rst_thr", {new_tlb_thread_id, fault_thread_id}, 0);

        // Basic fill at minimum latency.
        issue(2'd1, 32'h0000_3ABC, 20'h08000);
        check("basic_addr", mem_req_addr, 20'h0800C);
        finish(0, 0, 32'h0005_5001, 1'b0, 2'd1, 32'h0000_3ABC, 20'h08000);
        check("basic_pa_held", new_tlb_info.phy_addr, 20'h55ABC);
        check("basic_va_held", new_tlb_info.virt_addr, 32'h0000_3ABC);

        // Arbiter stall.
        issue(2'd2, 32'h1234_5678, 20'h10000);
        finish(5, 1, 32'h000A_B003, 1'b0, 2'd2, 32'h1234_5678, 20'h10000);

        // Invalid PTE.
        issue(2'd3, 32'h0000_7000, 20'h20000);
        finish(0, 0, 32'h0005_5000, 1'b0, 2'd3, 32'h0000_7000, 20'h20000);

        // Timeout, then a late response in IDLE must be ignored.
        issue(2'd0, 32'h0000_1000, 20'h30000);
        finish(0, 0, 32'h0, 1'b1, 2'd0, 32'h0000_1000, 20'h30000);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0001_2001;
        repeat (2) begin
            @(negedge clock);
            check("late_rsp_no_fill", new_tlb_entry, 0);
            check("late_rsp_idle", {miss_ready, mem_req_valid}, 2'b10);
        end
        mem_rsp_valid = 1'b0;

        // Response on the very cycle the limit is reached still fills.
        issue(2'd1, 32'h0000_5ABC, 20'h00100);
        finish(0, TIMEOUT, 32'h0007_7001, 1'b0, 2'd1, 32'h0000_5ABC, 20'h00100);

        // Back-to-back: second miss held during the first walk.
        issue(2'd2, 32'h0000_A111, 20'h40000);
        miss_valid = 1'b1; miss_thread_id = 2'd3; miss_virt_addr = 32'h0000_B222; pt_base = 20'h50000;
        finish(2, 1, 32'h0001_1001, 1'b0, 2'd2, 32'h0000_A111, 20'h40000);
        issue(2'd3, 32'h0000_B222, 20'h50000);
        check("b2b_first_info_held", new_tlb_info.phy_addr, 20'h11111);
        finish(0, 0, 32'h0002_2001, 1'b0, 2'd3, 32'h0000_B222, 20'h50000);

        // Reset while waiting for the response.
        issue(2'd1, 32'h0000_C000, 20'h60000);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_miss_ready", miss_ready, 1);
        check("midrst_pulses", {new_tlb_entry, walk_fault}, 0);
        check("midrst_req_valid", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0003_3001;
        repeat (2) begin
            @(negedge clock);
            check("midrst_rsp_ignored", {new_tlb_entry, walk_fault}, 0);
        end
        mem_rsp_valid = 1'b0;

        // Address wrap at PA_WIDTH.
        issue(2'd0, 32'h0000_2123, 20'hFFFFC);
        check("wrap_addr", mem_req_addr, 20'h00004);
        finish(0, 0, 32'h0004_4001, 1'b0, 2'd0, 32'h0000_2123, 20'hFFFFC);

        // Randomized walks.
        for (int k = 0; k < 40; k++) begin
            thr  = THR_W'($urandom);
            va   = $urandom;
            base = 20'($urandom);
            pte  = $urandom;
            issue(thr, va, base);
            finish(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), pte, 1'b0, thr, va, base);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
